// File: rtl/fullchip_pkg.sv
// Shared constants and types for the psum transfer path.
// Contents:
//   COL_DEF / BW_PSUM_DEF / DEPTH_DEF - default lane count, lane width, FIFO depth
//   SUM_GUARD                         - guard bits added on top of the lane width
//   SUM_W_DEF                         - default width of a row/accumulated sum
//   acc_state_e                       - accumulator FSM state encoding
package fullchip_pkg;

  localparam int COL_DEF     = 8;
  localparam int BW_PSUM_DEF = 20;
  localparam int DEPTH_DEF   = 8;
  localparam int SUM_GUARD   = 4;
  localparam int SUM_W_DEF   = BW_PSUM_DEF + SUM_GUARD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sum_fifo.sv
// Transmit FIFO for accumulated sums, show-ahead read port.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push_i, data_i    - write strobe and data
//   pop_i             - peer pop strobe (ignored while empty)
//   data_o            - head entry, forced to 0 while empty
//   empty_o, full_o   - occupancy flags
//   ovf_o, udf_o      - sticky flags: push dropped while full / pop while empty
// depth must be a power of two, at least 2.
module sum_fifo
  import fullchip_pkg::*;
#(
  parameter int width = SUM_W_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [width-1:0] data_i,
  input  logic             pop_i,
  output logic [width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !do_push) ovf_d = 1'b1;
    if (pop_i && empty_o)   udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign ovf_o  = ovf_q;
  assign udf_o  = udf_q;

endmodule

// File: rtl/sum_xfer_tx.sv
// Sum-of-absolute-values transfer path: per valid psum row, sums |lane| over
// all lanes, accumulates rows until psum_last, then pushes the total into a
// transmit FIFO read by the peer via fifo_ext_rd.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   psum_in             - col signed lanes, lane k at [k*bw_psum +: bw_psum]
//   psum_valid          - row valid strobe
//   psum_last           - row closes the current accumulation
//   fifo_ext_rd         - peer pop strobe
//   sum_out             - FIFO head (0 while empty)
//   empty, full         - FIFO occupancy flags
//   ovf, udf            - sticky overflow / underflow flags
// Build option: define SUM_XFER_TX_SAT_EN to saturate the accumulator and the
// pushed value at all-ones instead of wrapping.
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | no partial sum, acc_q is zero
// ST_ACC  | partial sum of earlier rows held in acc_q
module sum_xfer_tx
  import fullchip_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int bw_psum = BW_PSUM_DEF,
  parameter int depth   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] psum_in,
  input  logic                   psum_valid,
  input  logic                   psum_last,
  input  logic                   fifo_ext_rd,
  output logic [bw_psum+3:0]     sum_out,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   udf
);

  localparam int SW = bw_psum + SUM_GUARD;

  logic [bw_psum-1:0] lane_mag [col];
  logic [SW-1:0]      row_abs;

  logic               s1_valid_q, s1_last_q;
  logic [SW-1:0]      s1_abs_q;

  acc_state_e         state_q, state_d;
  logic [SW-1:0]      acc_q, acc_d;
  logic [SW-1:0]      acc_sum;
  logic               push;
  logic [SW-1:0]      push_data;

  // Two's-complement negate of the most-negative lane yields 2^(bw_psum-1),
  // which is exact when read back as unsigned.
  for (genvar k = 0; k < col; k++) begin : g_abs
    logic [bw_psum-1:0] lane;
    assign lane        = psum_in[k*bw_psum +: bw_psum];
    assign lane_mag[k] = lane[bw_psum-1] ? (-lane) : lane;
  end

  always_comb begin
    row_abs = '0;
    for (int k = 0; k < col; k++) row_abs = row_abs + SW'(lane_mag[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_abs_q   <= '0;
    end else begin
      s1_valid_q <= psum_valid;
      s1_last_q  <= psum_valid && psum_last;
      s1_abs_q   <= row_abs;
    end
  end

`ifdef SUM_XFER_TX_SAT_EN
  logic [SW:0] acc_wide;
  assign acc_wide = {1'b0, acc_q} + {1'b0, s1_abs_q};
  assign acc_sum  = acc_wide[SW] ? '1 : acc_wide[SW-1:0];
`else
  assign acc_sum  = acc_q + s1_abs_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (s1_valid_q) state_d = s1_last_q ? ST_IDLE : ST_ACC;
  end

  // acc_q clears on every closing row, including one the FIFO drops.
  always_comb begin
    acc_d     = acc_q;
    push      = 1'b0;
    push_data = acc_sum;
    if (s1_valid_q) begin
      if (s1_last_q) begin
        push  = 1'b1;
        acc_d = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  sum_fifo #(
    .width (SW),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (fifo_ext_rd),
    .data_o  (sum_out),
    .empty_o (empty),
    .full_o  (full),
    .ovf_o   (ovf),
    .udf_o   (udf)
  );

endmodule

// File: tb/tb_sum_xfer_tx.sv
module tb_sum_xfer_tx;

  localparam int COL = 8;
  localparam int BW  = 20;
  localparam int SW  = BW + 4;
  localparam int RW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] psum_in;
  logic          psum_valid;
  logic          psum_last;
  logic          fifo_ext_rd;
  logic [SW-1:0] sum_out;
  logic          empty, full, ovf, udf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sum_xfer_tx #(.col(COL), .bw_psum(BW), .depth(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .psum_in     (psum_in),
    .psum_valid  (psum_valid),
    .psum_last   (psum_last),
    .fifo_ext_rd (fifo_ext_rd),
    .sum_out     (sum_out),
    .empty       (empty),
    .full        (full),
    .ovf         (ovf),
    .udf         (udf)
  );

  typedef struct {
    logic [RW-1:0] row;
    logic [SW-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [RW-1:0] mk_row(input int l0, input int l1, input int l2,
                                           input int l3, input int l4, input int l5,
                                           input int l6, input int l7);
    int            l[8];
    logic [RW-1:0] r;
    l = '{l0, l1, l2, l3, l4, l5, l6, l7};
    r = '0;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = l[k][BW-1:0];
    return r;
  endfunction

  function automatic logic [RW-1:0] mk_uni(input int v);
    return mk_row(v, v, v, v, v, v, v, v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input logic [RW-1:0] row, input logic last);
    psum_in    = row;
    psum_valid = 1'b1;
    psum_last  = last;
    tick();
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    psum_in    = '0;
  endtask

  task automatic pop();
    fifo_ext_rd = 1'b1;
    tick();
    fifo_ext_rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_sum_out"}, sum_out, 0);
    check({tag, "_empty"},   empty,   1);
    check({tag, "_full"},    full,    0);
    check({tag, "_ovf"},     ovf,     0);
    check({tag, "_udf"},     udf,     0);
  endtask

  initial begin
    logic [SW-1:0] exp_sat;

    vecs[0] = '{mk_row(1, -2, 3, -4, 5, -6, 7, -8), 24'd36};
    vecs[1] = '{mk_uni(0), 24'd0};
    vecs[2] = '{mk_uni(-524288), 24'd4194304};
    vecs[3] = '{mk_uni(524287), 24'd4194296};
    vecs[4] = '{mk_row(100, -100, 100, -100, 100, -100, 100, -100), 24'd800};
    vecs[5] = '{mk_uni(-1), 24'd8};

    reset       = 1'b1;
    psum_in     = '0;
    psum_valid  = 1'b0;
    psum_last   = 1'b0;
    fifo_ext_rd = 1'b0;
    tick();
    tick();
    check_reset_outs("rst");
    reset = 1'b0;
    tick();

    // pop on empty after reset
    pop();
    check("udf_empty_pop", udf, 1);
    check("udf_empty_stays", empty, 1);
    check("udf_sum_out", sum_out, 0);
    do_reset();
    check("udf_cleared", udf, 0);

    // single closing rows from the table
    for (int i = 0; i < 6; i++) begin
      drive_row(vecs[i].row, 1'b1);
      check($sformatf("vec%0d_latency_empty", i), empty, 1);
      tick();
      check($sformatf("vec%0d_visible", i), empty, 0);
      check($sformatf("vec%0d_sum", i), sum_out, vecs[i].exp);
      pop();
      check($sformatf("vec%0d_drained", i), empty, 1);
    end

    // three-row accumulation, close on row 3
    drive_row(mk_uni(100), 1'b0);
    drive_row(mk_uni(100), 1'b0);
    drive_row(mk_uni(100), 1'b1);
    check("acc3_no_early_push", empty, 1);
    tick();
    check("acc3_visible", empty, 0);
    check("acc3_sum", sum_out, 2400);
    pop();
    check("acc3_one_entry", empty, 1);

    // fill to full, overflow the ninth, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) drive_row(mk_uni(i + 1), 1'b1);
    tick();
    check("fill_full", full, 1);
    check("fill_no_ovf", ovf, 0);
    drive_row(mk_uni(9), 1'b1);
    tick();
    check("ovf_set", ovf, 1);
    check("ovf_still_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), sum_out, 8 * (i + 1));
      pop();
    end
    check("drain_empty", empty, 1);
    check("drain_not_full", full, 0);
    drive_row(mk_uni(1), 1'b1);
    tick();
    check("acc_cleared_after_drop", sum_out, 8);
    pop();

    // push and pop together while full
    do_reset();
    for (int i = 0; i < 8; i++) drive_row(mk_uni(i + 1), 1'b1);
    tick();
    drive_row(mk_uni(50), 1'b1);
    pop();
    check("pp_full_still_full", full, 1);
    check("pp_full_no_ovf", ovf, 0);
    check("pp_full_head", sum_out, 16);
    for (int i = 0; i < 7; i++) pop();
    check("pp_full_tail", sum_out, 400);

    // push and pop together while empty
    do_reset();
    drive_row(mk_uni(3), 1'b1);
    pop();
    check("pp_empty_udf", udf, 1);
    check("pp_empty_accepted", empty, 0);
    check("pp_empty_sum", sum_out, 24);

    // reset in the middle of an accumulation
    do_reset();
    pop();
    drive_row(mk_uni(2), 1'b1);
    drive_row(mk_uni(5), 1'b0);
    drive_row(mk_uni(5), 1'b0);
    tick();
    check("mid_pre_entry", empty, 0);
    reset = 1'b1;
    #1;
    check_reset_outs("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    drive_row(mk_uni(1), 1'b1);
    tick();
    check("mid_post_visible", empty, 0);
    check("mid_post_sum", sum_out, 8);

    // 20 rows of most-negative lanes: saturate or wrap
    do_reset();
`ifdef SUM_XFER_TX_SAT_EN
    exp_sat = 24'hFF_FFFF;
`else
    exp_sat = 24'd0;
`endif
    for (int i = 0; i < 20; i++) drive_row(mk_uni(-524288), (i == 19));
    tick();
    check("big_visible", empty, 0);
    check("big_sum", sum_out, exp_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
